// File: rtl/mcpu_alu_arbiter.sv
// mcpu_alu_arbiter: two-requester round-robin front end for a shared,
// multi-cycle ALU. It registers the winning operation onto the ALU ports,
// waits a fixed settling time, captures the result and emits a one-cycle
// response pulse tagged with the owning requester. Illegal opcodes skip
// the ALU entirely and come back as an error response on the next cycle.
module mcpu_alu_arbiter #(
  parameter int CMD_SIZE  = 3,
  parameter int WORD_SIZE = 16,
  parameter int ALU_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [CMD_SIZE-1:0]  req0_cmd,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [CMD_SIZE-1:0]  req1_cmd,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  output logic [CMD_SIZE-1:0]  alu_cmd,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_cf,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_cf,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [CMD_SIZE-1:0] OP_ADD    = CMD_SIZE'(3);
  localparam logic [CMD_SIZE-1:0] OP_SUB    = CMD_SIZE'(4);
  localparam logic [CMD_SIZE-1:0] OP_LAST   = CMD_SIZE'(5);
  localparam logic [3:0]          WAIT_LOAD = 4'(ALU_LAT - 1);

  state_t               state;
  logic                 last_grant;
  logic                 owner;
  logic [3:0]           wait_cnt;
  logic                 grant0;
  logic                 grant1;
  logic                 accept;
  logic [CMD_SIZE-1:0]  sel_cmd;
  logic [WORD_SIZE-1:0] sel_a;
  logic [WORD_SIZE-1:0] sel_b;

  // Round-robin winner selection; ready only offered to the winner while idle and out of reset
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = rst_n && (state == IDLE) && grant0;
    req1_ready = rst_n && (state == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    sel_cmd    = req1_ready ? req1_cmd : req0_cmd;
    sel_a      = req1_ready ? req1_a   : req0_a;
    sel_b      = req1_ready ? req1_b   : req0_b;
  end

  assign busy = (state != IDLE);

  // Control FSM: accept, wait for the ALU to settle, then pulse the response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      alu_cmd    <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_cf     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= req1_ready;
            owner      <= req1_ready;
            if (sel_cmd > OP_LAST) begin
              rsp_data  <= '0;
              rsp_cf    <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_id    <= req1_ready;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_cmd  <= sel_cmd;
              alu_in1  <= sel_a;
              alu_in2  <= sel_b;
              wait_cnt <= WAIT_LOAD;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_data  <= alu_out;
            rsp_cf    <= ((alu_cmd == OP_ADD) || (alu_cmd == OP_SUB)) ? alu_cf : 1'b0;
            rsp_err   <= 1'b0;
            rsp_id    <= owner;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mcpu_alu_arbiter.md
MCPU_ALU_ARBITER -- requirements
Module: mcpu_alu_arbiter

Interface
REQ-001 Parameter CMD_SIZE, default 3, width of ALU command field.
REQ-002 Parameter WORD_SIZE, default 16, width of ALU operands and result.
REQ-003 Parameter ALU_LAT, default 2, number of WAIT cycles allowed for ALU settling; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-007 req0_ready / req1_ready  output  1  requester N's operation is accepted this edge.
REQ-008 req0_cmd / req1_cmd  input  CMD_SIZE  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 NOT; 6-7 illegal.
REQ-009 req0_a, req0_b / req1_a, req1_b  input  WORD_SIZE  operands.
REQ-010 alu_cmd  output  CMD_SIZE  registered command to shared ALU.
REQ-011 alu_in1, alu_in2  output  WORD_SIZE  registered operands to shared ALU.
REQ-012 alu_out  input  WORD_SIZE  ALU result.
REQ-013 alu_cf  input  1  ALU carry/borrow flag.
REQ-014 rsp_valid  output  1  one-cycle response pulse.
REQ-015 rsp_id  output  1  requester that owns the response (0 or 1).
REQ-016 rsp_data  output  WORD_SIZE  captured result.
REQ-017 rsp_cf  output  1  captured carry flag.
REQ-018 rsp_err  output  1  response is for an illegal opcode.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 States SHALL be IDLE, WAIT, RESP; encoding free.
REQ-021 Acceptance occurs at a rising edge where reqN_valid and reqN_ready are both high; at most one requester accepted per edge.
REQ-022 reqN_ready SHALL be combinational from state, valids and priority pointer only; high only in IDLE, only for the arbitration winner, and only while that requester's valid is high.
REQ-023 Arbitration: single valid wins; both valid -> requester not granted last wins (round-robin); pointer updates on each acceptance only.
REQ-024 Legal accept: alu_cmd/alu_in1/alu_in2 load the winner's cmd/a/b, owner id recorded, wait counter loaded, IDLE -> WAIT.
REQ-025 WAIT SHALL last exactly ALU_LAT cycles; on the edge ending the last WAIT cycle, rsp_data <= alu_out, rsp_cf <= alu_cf for ADD/SUB else 0, rsp_err <= 0, state -> RESP.
REQ-026 Illegal accept (cmd 6 or 7): alu_* registers unchanged, rsp_data <= 0, rsp_cf <= 0, rsp_err <= 1, IDLE -> RESP directly.
REQ-027 RESP: rsp_valid = 1 for exactly one cycle, rsp_id = owner; next edge -> IDLE. No response backpressure.
REQ-028 Latency: legal op accepted at edge k -> rsp_valid high between edges k+ALU_LAT and k+ALU_LAT+1; illegal op -> between edges k and k+1.
REQ-029 Throughput: next acceptance no earlier than edge following the RESP cycle (legal-op period ALU_LAT+2 cycles).
REQ-030 rsp_data/rsp_cf/rsp_err/rsp_id SHALL hold their values after the pulse until the next capture.
REQ-031 alu_* outputs SHALL stay stable from acceptance until the next legal acceptance.
REQ-032 Request inputs changing while not accepted SHALL have no effect; no request is queued internally.

Reset
REQ-033 rst_n low at a rising edge: state IDLE, all outputs and registers 0 (rsp_valid, rsp_id, rsp_data, rsp_cf, rsp_err, busy, alu_cmd, alu_in1, alu_in2), pointer set so req0 wins the first tie.
REQ-034 Reset during WAIT or RESP SHALL abandon the operation; no rsp_valid is produced for it.
REQ-035 While rst_n is low, req0_ready and req1_ready SHALL be 0.

Verification
REQ-036 Req0 ADD a=0xFFFF b=0x0001 at edge k, ALU_LAT=2 -> alu_cmd=3, rsp_valid high between k+2 and k+3, rsp_id=0, rsp_data=0x0000, rsp_cf=1.
REQ-037 Both valid continuously, req0 XOR 0x00FF^0x0F0F, req1 SUB 0x0003-0x0005 -> grants alternate 0,1,0,..., req0 rsp_data=0x0FF0 rsp_cf=0, req1 rsp_data=0xFFFE rsp_cf=1.
REQ-038 Req1 cmd=7 -> rsp_valid next cycle, rsp_err=1, rsp_data=0, alu_* unchanged from prior op.
REQ-039 Req0 AND accepted, rst_n low one cycle during WAIT -> no rsp_valid, all outputs 0, busy=0 after reset edge.
REQ-040 Req1 OR 0x1200|0x0034 with req0 idle, then req0 valid during WAIT -> req0_ready stays 0 until IDLE, req1 response 0x1234 precedes req0 acceptance.
